// File: rtl/ofdm_pkg.sv
// Shared constants, state encoding and helpers for the OFDM pixel/symbol kernels.
package ofdm_pkg;

  localparam int SYM_BITS_DEF = 2;
  localparam int PIX_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Symbols carried by one pixel.
  function automatic int calc_spp(input int pix_bits, input int sym_bits);
    return pix_bits / sym_bits;
  endfunction

endpackage

// File: rtl/sym_packer.sv
// Symbol accumulator: shifts symbols in MSB-first and produces the pixel,
// zero-padded at the LSBs when the pixel is cut short by a flush.
module sym_packer
  import ofdm_pkg::*;
#(
  parameter int SYM_BITS = SYM_BITS_DEF,
  parameter int PIX_BITS = PIX_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_shift,
  input  logic                i_flush,
  input  logic [SYM_BITS-1:0] i_sym,
  output logic [PIX_BITS-1:0] o_pixel,
  output logic                o_complete
);

  localparam int SPP = calc_spp(PIX_BITS, SYM_BITS);
  localparam int CNT_W = $clog2(SPP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPP - 1);

  logic [PIX_BITS-1:0] r_acc;
  logic [PIX_BITS-1:0] w_acc_next;
  logic [CNT_W-1:0]    r_sym_cnt;
  logic [CNT_W-1:0]    w_pad;

  // Next accumulator value and padded pixel; w_pad counts the missing symbols.
  always_comb begin
    w_acc_next = (r_acc << SYM_BITS) | PIX_BITS'(i_sym);
    w_pad      = CNT_MAX - r_sym_cnt;
    o_pixel    = w_acc_next << (SYM_BITS * int'(w_pad));
    o_complete = i_shift && ((r_sym_cnt == CNT_MAX) || i_flush);
  end

  // Shift register and symbol counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc     <= '0;
      r_sym_cnt <= '0;
    end else if (i_clear || o_complete) begin
      r_acc     <= '0;
      r_sym_cnt <= '0;
    end else if (i_shift) begin
      r_acc     <= w_acc_next;
      r_sym_cnt <= r_sym_cnt + CNT_W'(1);
    end else begin
      r_acc     <= r_acc;
      r_sym_cnt <= r_sym_cnt;
    end
  end

endmodule

// File: rtl/symbol_to_pixl.sv
// Receive-side symbol-to-pixel packer with ap_ctrl start/done/idle handshake
// and stream blocking flags for the deadlock monitor.
module symbol_to_pixl
  import ofdm_pkg::*;
#(
  parameter int SYM_BITS = SYM_BITS_DEF,
  parameter int PIX_BITS = PIX_BITS_DEF,
  parameter int LEN_W    = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic [7:0]          data_in_TDATA,
  input  logic                data_in_TVALID,
  output logic                data_in_TREADY,
  input  logic                data_in_TLAST,
  output logic [PIX_BITS-1:0] data_out_TDATA,
  output logic                data_out_TVALID,
  input  logic                data_out_TREADY,
  output logic                data_out_TLAST,
  output logic                data_in_TDATA_blk_n,
  output logic                data_out_TDATA_blk_n,
  output logic                len_err
);

  state_e              r_state;
  state_e              w_state_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_pix_cnt;
  logic                r_len_err;
  logic                r_done;
  logic                r_idle;
  logic [PIX_BITS-1:0] r_out_data;
  logic                r_out_valid;
  logic                r_out_last;

  logic                w_in_ready;
  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_last_pix;
  logic                w_end;
  logic                w_clear;
  logic                w_complete;
  logic [PIX_BITS-1:0] w_pixel;
  logic                w_unused_tdata;

  assign w_unused_tdata = ^data_in_TDATA;

  // Stream handshakes and frame-boundary decode.
  always_comb begin
    w_in_ready = (r_state == ST_RUN) && (!r_out_valid || data_out_TREADY);
    w_in_hs    = w_in_ready && data_in_TVALID;
    w_out_hs   = r_out_valid && data_out_TREADY;
    w_last_pix = (r_pix_cnt == (r_len - LEN_W'(1)));
    w_end      = w_complete && (w_last_pix || data_in_TLAST);
    w_clear    = (r_state == ST_IDLE) && ap_start;
  end

  sym_packer #(
    .SYM_BITS(SYM_BITS),
    .PIX_BITS(PIX_BITS)
  ) u_packer (
    .i_clk      (ap_clk),
    .i_rst_n    (ap_rst_n),
    .i_clear    (w_clear),
    .i_shift    (w_in_hs),
    .i_flush    (data_in_TLAST),
    .i_sym      (data_in_TDATA[SYM_BITS-1:0]),
    .o_pixel    (w_pixel),
    .o_complete (w_complete)
  );

  // Frame control next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ap_start) begin
          w_state_next = (frame_len == '0) ? ST_DONE : ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_end) begin
          w_state_next = ST_DRAIN;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_out_hs) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register with registered idle/done flags.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == ST_DONE);
      r_idle  <= (w_state_next == ST_IDLE);
    end
  end

  // Frame context; TLAST and the final pixel must coincide, otherwise len_err.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_len     <= '0;
      r_pix_cnt <= '0;
      r_len_err <= 1'b0;
    end else if (w_clear) begin
      r_len     <= frame_len;
      r_pix_cnt <= '0;
      r_len_err <= 1'b0;
    end else if (w_complete) begin
      r_pix_cnt <= r_pix_cnt + LEN_W'(1);
      r_len_err <= r_len_err | (data_in_TLAST ^ w_last_pix);
    end else begin
      r_pix_cnt <= r_pix_cnt;
      r_len_err <= r_len_err;
    end
  end

  // Output register: a new pixel wins over a same-cycle drain.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_complete) begin
      r_out_data  <= w_pixel;
      r_out_valid <= 1'b1;
      r_out_last  <= w_last_pix || data_in_TLAST;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_last  <= r_out_last;
    end
  end

  assign ap_done              = r_done;
  assign ap_idle              = r_idle;
  assign len_err              = r_len_err;
  assign data_in_TREADY       = w_in_ready;
  assign data_out_TDATA       = r_out_data;
  assign data_out_TVALID      = r_out_valid;
  assign data_out_TLAST       = r_out_last;
  assign data_in_TDATA_blk_n  = !(w_in_ready && !data_in_TVALID);
  assign data_out_TDATA_blk_n = !(r_out_valid && !data_out_TREADY);

endmodule

// File: tb/tb_symbol_to_pixl.sv
// Directed self-checking bench for symbol_to_pixl at default parameters.
module tb_symbol_to_pixl;

  localparam int LEN_W = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic [LEN_W-1:0] frame_len;
  logic [7:0]       data_in_TDATA;
  logic             data_in_TVALID;
  logic             data_in_TREADY;
  logic             data_in_TLAST;
  logic [7:0]       data_out_TDATA;
  logic             data_out_TVALID;
  logic             data_out_TREADY;
  logic             data_out_TLAST;
  logic             data_in_TDATA_blk_n;
  logic             data_out_TDATA_blk_n;
  logic             len_err;

  symbol_to_pixl #(.SYM_BITS(2), .PIX_BITS(8), .LEN_W(LEN_W)) dut (
    .ap_clk               (ap_clk),
    .ap_rst_n             (ap_rst_n),
    .ap_start             (ap_start),
    .ap_done              (ap_done),
    .ap_idle              (ap_idle),
    .frame_len            (frame_len),
    .data_in_TDATA        (data_in_TDATA),
    .data_in_TVALID       (data_in_TVALID),
    .data_in_TREADY       (data_in_TREADY),
    .data_in_TLAST        (data_in_TLAST),
    .data_out_TDATA       (data_out_TDATA),
    .data_out_TVALID      (data_out_TVALID),
    .data_out_TREADY      (data_out_TREADY),
    .data_out_TLAST       (data_out_TLAST),
    .data_in_TDATA_blk_n  (data_in_TDATA_blk_n),
    .data_out_TDATA_blk_n (data_out_TDATA_blk_n),
    .len_err              (len_err)
  );

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0;
  int n_pass = 0;

  // Frame stimulus and collected results
  logic [7:0] sym_q [16];
  int         n_sym;
  int         last_idx;
  int         stall_len;
  logic [7:0] pix_q [8];
  logic       last_q [8];
  int         n_pix;
  int         n_acc;
  bit         done_seen;
  int         done_cyc;
  int         stall_seen;
  int         stall_bad;

  // Runs one frame: start, offer symbols, collect pixels until ap_done or budget.
  task automatic drive_frame(input logic [LEN_W-1:0] len, input int max_cyc);
    int         idx = 0;
    int         stall_left = 0;
    bit         stall_started = 0;
    logic [7:0] held = 8'h00;
    n_pix = 0; n_acc = 0; done_seen = 0; done_cyc = -1; stall_seen = 0; stall_bad = 0;
    for (int cyc = 0; cyc < max_cyc && !done_seen; cyc++) begin
      @(negedge ap_clk);
      ap_start  = (cyc == 0);
      frame_len = len;
      if (stall_len > 0 && !stall_started && data_out_TVALID === 1'b1 && n_pix == 0) begin
        stall_started = 1;
        stall_left    = stall_len;
        held          = data_out_TDATA;
      end
      data_out_TREADY = (stall_left == 0);
      data_in_TVALID  = (idx < n_sym);
      data_in_TDATA   = (idx < n_sym) ? (sym_q[idx] | 8'hA8) : 8'h00;
      data_in_TLAST   = (idx == last_idx);
      #1;
      if (stall_left > 0) begin
        stall_seen++;
        if (data_out_TDATA !== held || data_out_TVALID !== 1'b1 ||
            data_in_TREADY !== 1'b0 || data_out_TDATA_blk_n !== 1'b0) stall_bad++;
        stall_left--;
      end
      if (ap_done === 1'b1) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (data_out_TVALID === 1'b1 && data_out_TREADY) begin
        if (n_pix < 8) begin
          pix_q[n_pix]  = data_out_TDATA;
          last_q[n_pix] = data_out_TLAST;
        end
        n_pix++;
      end
      if (data_in_TVALID && data_in_TREADY === 1'b1) begin
        idx++;
        n_acc++;
      end
    end
    ap_start        = 1'b0;
    data_in_TVALID  = 1'b0;
    data_in_TLAST   = 1'b0;
    data_out_TREADY = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (ap_idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", ap_idle); else n_pass++;
    n_chk++; if (ap_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", ap_done); else n_pass++;
    n_chk++; if (data_in_TREADY !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", data_in_TREADY); else n_pass++;
    n_chk++; if ({data_out_TVALID, data_out_TLAST, len_err} !== 3'b000)
      $display("FAIL reset_out_flags: got %b expected 000", {data_out_TVALID, data_out_TLAST, len_err}); else n_pass++;
    n_chk++; if (data_out_TDATA !== 8'h00) $display("FAIL reset_data: got %h expected 00", data_out_TDATA); else n_pass++;
    n_chk++; if ({data_in_TDATA_blk_n, data_out_TDATA_blk_n} !== 2'b11)
      $display("FAIL reset_blk_n: got %b expected 11", {data_in_TDATA_blk_n, data_out_TDATA_blk_n}); else n_pass++;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    sym_q = '{0: 8'd3, 1: 8'd0, 2: 8'd1, 3: 8'd2, 4: 8'd1, 5: 8'd1, 6: 8'd1, 7: 8'd1, default: 8'd0};
    n_sym = 8; last_idx = 7; stall_len = 0;
    drive_frame(16'd2, 60);
    n_chk++; if (!done_seen) $display("FAIL basic_done: got timeout expected ap_done"); else n_pass++;
    n_chk++; if (n_pix !== 2) $display("FAIL basic_npix: got %0d expected 2", n_pix); else n_pass++;
    n_chk++; if (pix_q[0] !== 8'hC6 || last_q[0] !== 1'b0)
      $display("FAIL basic_pix0: got %h/%b expected c6/0", pix_q[0], last_q[0]); else n_pass++;
    n_chk++; if (pix_q[1] !== 8'h55 || last_q[1] !== 1'b1)
      $display("FAIL basic_pix1: got %h/%b expected 55/1", pix_q[1], last_q[1]); else n_pass++;
    n_chk++; if (len_err !== 1'b0) $display("FAIL basic_len_err: got %b expected 0", len_err); else n_pass++;
    n_chk++; if (n_acc !== 8) $display("FAIL basic_nacc: got %0d expected 8", n_acc); else n_pass++;
    @(negedge ap_clk); #1;
    n_chk++; if ({ap_done, ap_idle} !== 2'b01)
      $display("FAIL basic_after_done: got done/idle %b expected 01", {ap_done, ap_idle}); else n_pass++;
  endtask

  task automatic test_back_pressure();
    sym_q = '{0: 8'd3, 1: 8'd0, 2: 8'd1, 3: 8'd2, 4: 8'd1, 5: 8'd1, 6: 8'd1, 7: 8'd1, default: 8'd0};
    n_sym = 8; last_idx = 7; stall_len = 5;
    drive_frame(16'd2, 60);
    n_chk++; if (!done_seen) $display("FAIL bp_done: got timeout expected ap_done"); else n_pass++;
    n_chk++; if (stall_seen !== 5) $display("FAIL bp_stall_len: got %0d expected 5", stall_seen); else n_pass++;
    n_chk++; if (stall_bad !== 0) $display("FAIL bp_stall_hold: got %0d bad cycles expected 0", stall_bad); else n_pass++;
    n_chk++; if (n_pix !== 2 || pix_q[0] !== 8'hC6 || pix_q[1] !== 8'h55)
      $display("FAIL bp_pixels: got %0d px %h %h expected 2 px c6 55", n_pix, pix_q[0], pix_q[1]); else n_pass++;
    n_chk++; if (last_q[1] !== 1'b1 || len_err !== 1'b0)
      $display("FAIL bp_last_err: got last %b err %b expected 1 0", last_q[1], len_err); else n_pass++;
  endtask

  task automatic test_early_tlast();
    sym_q = '{0: 8'd3, 1: 8'd3, 2: 8'd3, 3: 8'd3, 4: 8'd2, default: 8'd0};
    n_sym = 5; last_idx = 4; stall_len = 0;
    drive_frame(16'd3, 60);
    n_chk++; if (!done_seen) $display("FAIL early_done: got timeout expected ap_done"); else n_pass++;
    n_chk++; if (n_pix !== 2 || pix_q[0] !== 8'hFF || last_q[0] !== 1'b0)
      $display("FAIL early_pix0: got %0d px %h/%b expected 2 px ff/0", n_pix, pix_q[0], last_q[0]); else n_pass++;
    n_chk++; if (pix_q[1] !== 8'h80 || last_q[1] !== 1'b1)
      $display("FAIL early_pad: got %h/%b expected 80/1", pix_q[1], last_q[1]); else n_pass++;
    n_chk++; if (len_err !== 1'b1) $display("FAIL early_len_err: got %b expected 1", len_err); else n_pass++;
  endtask

  task automatic test_missing_tlast();
    sym_q = '{0: 8'd1, 1: 8'd1, 2: 8'd1, 3: 8'd1, 4: 8'd1, default: 8'd0};
    n_sym = 5; last_idx = -1; stall_len = 0;
    drive_frame(16'd1, 60);
    n_chk++; if (!done_seen) $display("FAIL miss_done: got timeout expected ap_done"); else n_pass++;
    n_chk++; if (n_pix !== 1 || pix_q[0] !== 8'h55 || last_q[0] !== 1'b1)
      $display("FAIL miss_pix: got %0d px %h/%b expected 1 px 55/1", n_pix, pix_q[0], last_q[0]); else n_pass++;
    n_chk++; if (len_err !== 1'b1) $display("FAIL miss_len_err: got %b expected 1", len_err); else n_pass++;
    n_chk++; if (n_acc !== 4) $display("FAIL miss_fifth_beat: got %0d accepted expected 4", n_acc); else n_pass++;
  endtask

  task automatic test_zero_len();
    sym_q = '{default: 8'd3};
    n_sym = 1; last_idx = 0; stall_len = 0;
    drive_frame(16'd0, 20);
    n_chk++; if (done_cyc !== 1) $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); else n_pass++;
    n_chk++; if (n_pix !== 0 || n_acc !== 0)
      $display("FAIL zero_traffic: got %0d px %0d acc expected 0 0", n_pix, n_acc); else n_pass++;
    n_chk++; if (len_err !== 1'b0) $display("FAIL zero_err_cleared: got %b expected 0", len_err); else n_pass++;
    @(negedge ap_clk); #1;
    n_chk++; if ({ap_done, ap_idle} !== 2'b01)
      $display("FAIL zero_idle: got done/idle %b expected 01", {ap_done, ap_idle}); else n_pass++;
  endtask

  task automatic test_async_reset();
    int acc = 0;
    @(negedge ap_clk);
    frame_len = 16'd3; ap_start = 1'b1; data_in_TVALID = 1'b0;
    @(negedge ap_clk);
    ap_start = 1'b0;
    #1;
    n_chk++; if (data_in_TDATA_blk_n !== 1'b0) $display("FAIL in_blk_n_run: got %b expected 0", data_in_TDATA_blk_n); else n_pass++;
    data_in_TVALID = 1'b1; data_in_TDATA = 8'h03; data_in_TLAST = 1'b0;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      #1;
      if (data_in_TREADY === 1'b1) acc++;
      @(negedge ap_clk);
    end
    data_in_TVALID = 1'b0;
    n_chk++; if (acc !== 2) $display("FAIL rst_pre_symbols: got %0d expected 2", acc); else n_pass++;
    #2 ap_rst_n = 1'b0;
    #1;
    n_chk++; if ({ap_idle, ap_done, data_in_TREADY, data_out_TVALID, data_out_TLAST} !== 5'b10000)
      $display("FAIL rst_async_ctrl: got %b expected 10000",
               {ap_idle, ap_done, data_in_TREADY, data_out_TVALID, data_out_TLAST}); else n_pass++;
    n_chk++; if (data_out_TDATA !== 8'h00 || {data_in_TDATA_blk_n, data_out_TDATA_blk_n} !== 2'b11)
      $display("FAIL rst_async_data: got %h blk %b expected 00 blk 11",
               data_out_TDATA, {data_in_TDATA_blk_n, data_out_TDATA_blk_n}); else n_pass++;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    sym_q = '{0: 8'd2, 1: 8'd2, 2: 8'd2, 3: 8'd2, default: 8'd0};
    n_sym = 4; last_idx = 3; stall_len = 0;
    drive_frame(16'd1, 40);
    n_chk++; if (!done_seen) $display("FAIL rst_next_done: got timeout expected ap_done"); else n_pass++;
    n_chk++; if (n_pix !== 1 || pix_q[0] !== 8'hAA || last_q[0] !== 1'b1)
      $display("FAIL rst_next_pix: got %0d px %h/%b expected 1 px aa/1", n_pix, pix_q[0], last_q[0]); else n_pass++;
    n_chk++; if (len_err !== 1'b0) $display("FAIL rst_next_err: got %b expected 0", len_err); else n_pass++;
  endtask

  initial begin
    ap_rst_n        = 1'b0;
    ap_start        = 1'b0;
    frame_len       = '0;
    data_in_TDATA   = 8'h00;
    data_in_TVALID  = 1'b0;
    data_in_TLAST   = 1'b0;
    data_out_TREADY = 1'b1;
    test_reset();
    test_basic();
    test_back_pressure();
    test_early_tlast();
    test_missing_tlast();
    test_zero_len();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
